id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Decode/operand-fetch stage directly upstream of rf: extracts rs1/rs2/rd from an RV32I
//  instruction, drives the rf read ports, bypasses same-cycle writeback data, and holds a
//  32-entry pending-write scoreboard for RAW/WAW interlocks. Registers operands into the
//  ID/EX slot using a valid/ready handshake toward execute.
// PARAMETERS
//  XLEN      32  datapath width (instruction width fixed at 32)
//  NREGS     32  architectural registers; address width = $clog2(NREGS)
// PORTS
//  clk        in   1     clock, all state updates on posedge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     fetch presents an instruction
//  in_ready   out  1     stage accepts in_instr this cycle
//  in_instr   in   32    instruction word
//  in_pc      in   XLEN  PC of in_instr
//  rf_rs      out  5     rf read address 1 = in_instr[19:15]
//  rf_rt      out  5     rf read address 2 = in_instr[24:20]
//  rf_data1   in   XLEN  rf combinational read data 1
//  rf_data2   in   XLEN  rf combinational read data 2
//  wb_en      in   1     writeback strobe (same signal as rf write_e)
//  wb_rd      in   5     writeback register (same as rf rd)
//  wb_data    in   XLEN  writeback data (same as rf write_d)
//  flush      in   1     kill the ID/EX slot and block acceptance this cycle
//  out_valid  out  1     ID/EX slot holds a valid instruction
//  out_ready  in   1     execute consumes the slot this cycle
//  out_pc     out  XLEN  registered PC
//  out_instr  out  32    registered instruction
//  out_op1    out  XLEN  registered rs1 operand
//  out_op2    out  XLEN  registered rs2 operand
//  out_rd     out  5     registered destination
//  out_rd_we  out  1     instruction writes out_rd (0 when rd==x0)
// BEHAVIOUR
//  - Reset: out_valid=0, out_pc/out_instr/out_op1/out_op2=0, out_rd=0, out_rd_we=0, busy[]=0.
//  - Decode on opcode[6:0]: rd-write: LUI,AUIPC,JAL,JALR,LOAD,OP-IMM,OP. Uses rs1: JALR,BRANCH,
//    LOAD,STORE,OP-IMM,OP. Uses rs2: BRANCH,STORE,OP. Others: no reads/write, pass through.
//  - Operand select (combinational, per source): x0 -> 0; else wb_en&&wb_rd==src -> wb_data;
//    else rf_dataN. Bypass is needed because rf commits wb on the same edge.
//  - hazard = (uses_rs1 && rs1!=0 && busy[rs1] && !clr(rs1)) | same for rs2 |
//    (writes_rd && rd!=0 && busy[rd] && !clr(rd)); clr(r) = wb_en && wb_rd==r.
//  - in_ready = (!out_valid || out_ready) && !hazard && !flush. accept = in_valid && in_ready.
//  - On accept: slot loads pc/instr/op1/op2/rd; out_rd_we = writes_rd && rd!=0; out_valid=1.
//  - out_valid && out_ready && !accept -> out_valid=0. Slot is stable while out_valid&&!out_ready.
//  - flush: out_valid=0 next cycle, no accept; slot contents may hold stale data.
//  - Scoreboard per cycle, in order: clear wb_rd if wb_en && wb_rd!=0; clear out_rd if flush &&
//    out_valid && out_rd_we; set rd on accept with out_rd_we. Set wins over same-cycle clear.
//  - wb to a non-busy register: clear is a no-op; bypass still applies.
//  - Latency: 1 cycle from accept to out_valid. Throughput 1/cycle with no hazards.
//  - x0 never busy; writes to x0 never stall, never set busy.
//  - Async reset mid-operation: slot and scoreboard clear immediately; in_ready follows
//    combinationally from the cleared state.
// TESTING
//  1 Reset: rst_n=0 with in_valid=1 -> out_valid=0, busy all 0; release -> accepts next edge.
//  2 RAW interlock: issue ADDI x4,x0,42 then ADD x5,x4,x0 -> in_ready=0 until wb_en,
//    wb_rd=4, wb_data=42; same cycle accepts with out_op1=42 (bypass, rf_data1 stale).
//  3 Back-pressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0; out_ready=1 ->
//    next instr loads same edge, no bubble.
//  4 WAW: ADDI x2 pending, then ADDI x2 -> stall; wb_rd=2 clears and re-sets busy[2] same edge.
//  5 Flush: slot holds ADDI x7 (busy[7]=1), flush=1 with in_valid -> out_valid=0, busy[7]=0,
//    no accept that cycle.
//  6 x0: ADD x0,x0,x0 back-to-back with wb_rd=0 -> no stall, out_rd_we=0, op1=op2=0.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: RV32I field extraction, writeback bypass, pending-write
// scoreboard for RAW/WAW interlocks, and a valid/ready ID/EX slot toward execute.
module id_operand_stage #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic [AW-1:0]   rf_rs,
   output logic [AW-1:0]   rf_rt,
   input  logic [XLEN-1:0] rf_data1,
   input  logic [XLEN-1:0] rf_data2,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_op1,
   output logic [XLEN-1:0] out_op2,
   output logic [AW-1:0]   out_rd,
   output logic            out_rd_we
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [6:0]       opcode;
   logic [AW-1:0]    rs1, rs2, rd;
   logic             writes_rd, uses_rs1, uses_rs2;
   logic             rd_we_new;
   logic [XLEN-1:0]  op1, op2;
   logic             hazard, accept;
   logic [NREGS-1:0] busy, busy_next;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[7 +: AW];
   assign rs1    = in_instr[15 +: AW];
   assign rs2    = in_instr[20 +: AW];
   assign rf_rs  = rs1;
   assign rf_rt  = rs2;

   always_comb begin
      writes_rd = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            writes_rd = 1'b1;
            uses_rs1  = 1'b1;
         end
         OPC_OP: begin
            writes_rd = 1'b1;
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
         end
         OPC_BRANCH, OPC_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         default: ;
      endcase
   end

   assign rd_we_new = writes_rd && (rd != '0);

   // The rf commits writeback on the same edge we sample, so its read data is stale here.
   assign op1 = (rs1 == '0) ? '0 : ((wb_en && wb_rd == rs1) ? wb_data : rf_data1);
   assign op2 = (rs2 == '0) ? '0 : ((wb_en && wb_rd == rs2) ? wb_data : rf_data2);

   assign hazard = (uses_rs1 && rs1 != '0 && busy[rs1] && !(wb_en && wb_rd == rs1)) ||
                   (uses_rs2 && rs2 != '0 && busy[rs2] && !(wb_en && wb_rd == rs2)) ||
                   (writes_rd && rd != '0 && busy[rd] && !(wb_en && wb_rd == rd));

   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   // Clears are applied before the set so a same-cycle reissue of rd stays busy.
   always_comb begin
      busy_next = busy;
      if (wb_en && wb_rd != '0) busy_next[wb_rd] = 1'b0;
      if (flush && out_valid && out_rd_we) busy_next[out_rd] = 1'b0;
      if (accept && rd_we_new) busy_next[rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= '0;
         out_valid <= 1'b0;
         out_pc    <= '0;
         out_instr <= '0;
         out_op1   <= '0;
         out_op2   <= '0;
         out_rd    <= '0;
         out_rd_we <= 1'b0;
      end else begin
         busy <= busy_next;
         if (flush)          out_valid <= 1'b0;
         else if (accept)    out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
         if (accept) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
            out_op1   <= op1;
            out_op2   <= op2;
            out_rd    <= rd;
            out_rd_we <= rd_we_new;
         end
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed interlock/flush/x0 scenarios followed by
// randomized traffic checked against a scoreboard-level model, with the rf modelled here.
module tb_id_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid, in_ready, wb_en, flush, out_valid, out_ready, out_rd_we;
   logic [31:0] in_instr, in_pc, rf_data1, rf_data2, wb_data;
   logic [31:0] out_pc, out_instr, out_op1, out_op2;
   logic [4:0]  rf_rs, rf_rt, wb_rd, out_rd;

   logic [31:0] rf_mem [32];
   logic [31:0] m_busy;
   logic        m_valid, m_rd_we;
   logic [31:0] m_pc, m_instr, m_op1, m_op2;
   logic [4:0]  m_rd;
   logic [4:0]  pend [$];
   logic        seen_ready;
   int          checks = 0;
   int          errors = 0;

   id_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rf_rs(rf_rs), .rf_rt(rf_rt),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_en(wb_en), .wb_rd(wb_rd),
      .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_op1(out_op1), .out_op2(out_op2),
      .out_rd(out_rd), .out_rd_we(out_rd_we)
   );

   always #5 clk = ~clk;

   // Register file stand-in: x0 holds garbage so the stage must force zero itself.
   assign rf_data1 = rf_mem[rf_rs];
   assign rf_data2 = rf_mem[rf_rt];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA5A5_0000 | i;
      end else if (wb_en && wb_rd != 5'd0) begin
         rf_mem[wb_rd] <= wb_data;
      end
   end

   function automatic logic f_writes(input logic [6:0] op);
      return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                        7'b0000011, 7'b0010011, 7'b0110011};
   endfunction

   function automatic logic f_uses1(input logic [6:0] op);
      return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
   endfunction

   function automatic logic f_uses2(input logic [6:0] op);
      return op inside {7'b1100011, 7'b0100011, 7'b0110011};
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      logic [31:0] w;
      w = 32'd0;
      w[31:20] = 12'(imm);
      w[19:15] = 5'(rs1);
      w[11:7]  = 5'(rd);
      w[6:0]   = 7'b0010011;
      return w;
   endfunction

   function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
      logic [31:0] w;
      w = 32'd0;
      w[24:20] = 5'(rs2);
      w[19:15] = 5'(rs1);
      w[11:7]  = 5'(rd);
      w[6:0]   = 7'b0110011;
      return w;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  op;
      case ($urandom_range(0, 9))
         0: op = 7'b0110111;
         1: op = 7'b0010111;
         2: op = 7'b1101111;
         3: op = 7'b1100111;
         4: op = 7'b1100011;
         5: op = 7'b0000011;
         6: op = 7'b0100011;
         7: op = 7'b0010011;
         8: op = 7'b0110011;
         default: op = 7'b1110011;
      endcase
      w = $urandom;
      w[6:0]   = op;
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      return w;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      m_busy  = 32'd0;
      m_valid = 1'b0;
      m_pc    = 32'd0;
      m_instr = 32'd0;
      m_op1   = 32'd0;
      m_op2   = 32'd0;
      m_rd    = 5'd0;
      m_rd_we = 1'b0;
      pend.delete();
   endtask

   task automatic checkOutput();
      checkValue("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
         checkValue("out_pc", out_pc, m_pc);
         checkValue("out_instr", out_instr, m_instr);
         checkValue("out_op1", out_op1, m_op1);
         checkValue("out_op2", out_op2, m_op2);
         checkValue("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
         checkValue("out_rd_we", {31'd0, out_rd_we}, {31'd0, m_rd_we});
      end
   endtask

   // One cycle: drive at the falling edge, predict and check the handshake, advance the model,
   // then check the registered slot at the next falling edge.
   task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                                input logic ordy, input logic fl, input logic we,
                                input logic [4:0] wrd, input logic [31:0] wdata);
      logic [4:0]  s1, s2, d;
      logic        stall, exp_ready, acc;
      logic [31:0] v1, v2, nb;
      in_valid = iv; in_instr = instr; in_pc = pc; out_ready = ordy;
      flush = fl; wb_en = we; wb_rd = wrd; wb_data = wdata;
      #1;
      s1 = instr[19:15];
      s2 = instr[24:20];
      d  = instr[11:7];
      stall = (f_uses1(instr[6:0]) && s1 != 0 && m_busy[s1] && !(we && wrd == s1)) ||
              (f_uses2(instr[6:0]) && s2 != 0 && m_busy[s2] && !(we && wrd == s2)) ||
              (f_writes(instr[6:0]) && d != 0 && m_busy[d] && !(we && wrd == d));
      exp_ready = (!m_valid || ordy) && !stall && !fl;
      acc = iv && exp_ready;
      v1 = (s1 == 0) ? 32'd0 : ((we && wrd == s1) ? wdata : rf_mem[s1]);
      v2 = (s2 == 0) ? 32'd0 : ((we && wrd == s2) ? wdata : rf_mem[s2]);
      seen_ready = in_ready;
      checkValue("rf_rs", {27'd0, rf_rs}, {27'd0, s1});
      checkValue("rf_rt", {27'd0, rf_rt}, {27'd0, s2});
      checkValue("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      nb = m_busy;
      if (we && wrd != 0) nb[wrd] = 1'b0;
      if (fl && m_valid && m_rd_we) nb[m_rd] = 1'b0;
      if (acc && f_writes(instr[6:0]) && d != 0) nb[d] = 1'b1;
      m_busy = nb;
      if (we && wrd != 0)
         for (int i = 0; i < pend.size(); i++)
            if (pend[i] == wrd) begin
               pend.delete(i);
               break;
            end
      if (m_valid && ordy && !fl && m_rd_we) pend.push_back(m_rd);
      if (fl) m_valid = 1'b0;
      else if (acc) begin
         m_valid = 1'b1;
         m_pc    = pc;
         m_instr = instr;
         m_op1   = v1;
         m_op2   = v2;
         m_rd    = d;
         m_rd_we = f_writes(instr[6:0]) && d != 0;
      end else if (ordy) m_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic lit(input string name, input logic act, input logic exp);
      checkValue(name, {31'd0, act}, {31'd0, exp});
   endtask

   initial begin
      logic [4:0]  r;
      logic        we;
      logic [4:0]  wrd;
      in_valid = 1'b1; in_instr = addi(1, 0, 1); in_pc = 32'd0; out_ready = 1'b0;
      flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      resetModel();
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      lit("reset_out_valid", out_valid, 1'b0);
      checkValue("reset_out_pc", out_pc, 32'd0);
      lit("reset_out_rd_we", out_rd_we, 1'b0);
      lit("reset_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;

      applyStimulus(1, addi(4, 0, 42), 32'h100, 1, 0, 0, 5'd0, 32'd0);
      lit("accept_after_reset", seen_ready, 1'b1);
      checkValue("addi_rd", {27'd0, out_rd}, 32'd4);
      applyStimulus(1, add(5, 4, 0), 32'h104, 1, 0, 0, 5'd0, 32'd0);
      lit("raw_stall", seen_ready, 1'b0);
      applyStimulus(1, add(5, 4, 0), 32'h104, 1, 0, 1, 5'd4, 32'd42);
      lit("raw_release", seen_ready, 1'b1);
      checkValue("raw_bypass_op1", out_op1, 32'd42);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, addi(6, 1, 5), 32'h108, 0, 0, 0, 5'd0, 32'd0);
         lit("backpressure_ready", seen_ready, 1'b0);
      end
      checkValue("backpressure_hold_pc", out_pc, 32'h104);
      applyStimulus(1, addi(6, 1, 5), 32'h108, 1, 0, 0, 5'd0, 32'd0);
      lit("backpressure_release", seen_ready, 1'b1);
      checkValue("backpressure_next_pc", out_pc, 32'h108);

      applyStimulus(1, addi(6, 0, 1), 32'h10c, 1, 0, 0, 5'd0, 32'd0);
      lit("waw_stall", seen_ready, 1'b0);
      applyStimulus(1, addi(6, 0, 1), 32'h10c, 1, 0, 1, 5'd6, 32'd7);
      lit("waw_release", seen_ready, 1'b1);
      lit("waw_rd_we", out_rd_we, 1'b1);

      applyStimulus(1, addi(7, 0, 1), 32'h110, 1, 0, 0, 5'd0, 32'd0);
      applyStimulus(1, addi(7, 0, 3), 32'h114, 0, 1, 0, 5'd0, 32'd0);
      lit("flush_no_accept", seen_ready, 1'b0);
      lit("flush_kills_slot", out_valid, 1'b0);
      applyStimulus(1, addi(7, 0, 3), 32'h114, 0, 0, 0, 5'd0, 32'd0);
      lit("flush_clears_busy", seen_ready, 1'b1);

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, add(0, 0, 0), 32'h118 + 4 * i, 1, 0, 1, 5'd0, 32'hDEAD_BEEF);
         lit("x0_no_stall", seen_ready, 1'b1);
         lit("x0_rd_we", out_rd_we, 1'b0);
         checkValue("x0_op1", out_op1, 32'd0);
         checkValue("x0_op2", out_op2, 32'd0);
      end

      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            flush = 1'b0;
            rst_n = 1'b0;
            #1;
            lit("async_reset_valid", out_valid, 1'b0);
            lit("async_reset_rd_we", out_rd_we, 1'b0);
            lit("async_reset_ready", in_ready, 1'b1);
            resetModel();
            @(negedge clk);
            rst_n = 1'b1;
         end
         we  = 1'b0;
         wrd = 5'($urandom_range(0, 31));
         if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
            we  = 1'b1;
            wrd = pend[0];
         end else if ($urandom_range(0, 7) == 0) begin
            r = 5'($urandom_range(0, 7));
            if (!m_busy[r]) begin
               we  = 1'b1;
               wrd = r;
            end
         end
         applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                       we, wrd, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
